// File: rtl/y_writeback_buffer_if.sv
// Request, flush, SRAM and status bundle of the Y writeback buffer.
// slave = buffer side, master = requester/SRAM side.
interface y_writeback_buffer_if #(
    parameter int ADDR_W = 11,
    parameter int VAL_W  = 48,
    parameter int ROW_W  = 256
);
    logic              wb_reqValid;
    logic              wb_reqReady;
    logic [ADDR_W-1:0] wb_reqAddr;
    logic [3:0]        wb_reqOneHot;
    logic [VAL_W-1:0]  wb_reqVal;
    logic              wb_flush;
    logic              sram_readEn;
    logic [ADDR_W-1:0] sram_readAddr;
    logic [ROW_W-1:0]  sram_readData;
    logic              sram_writeEn;
    logic [ADDR_W-1:0] sram_writeAddr;
    logic [ROW_W-1:0]  sram_writeData;
    logic              wb_idle;
    logic              wb_errOneHot;
    logic [15:0]       wb_writeCount;

    modport slave (
        input  wb_reqValid, wb_reqAddr, wb_reqOneHot, wb_reqVal, wb_flush, sram_readData,
        output wb_reqReady, sram_readEn, sram_readAddr, sram_writeEn, sram_writeAddr,
               sram_writeData, wb_idle, wb_errOneHot, wb_writeCount
    );

    modport master (
        output wb_reqValid, wb_reqAddr, wb_reqOneHot, wb_reqVal, wb_flush, sram_readData,
        input  wb_reqReady, sram_readEn, sram_readAddr, sram_writeEn, sram_writeAddr,
               sram_writeData, wb_idle, wb_errOneHot, wb_writeCount
    );
endinterface

// File: rtl/y_writeback_buffer.sv
// Queued lane read-modify-write into 256-bit Y SRAM rows; read 1 cycle after push, write 2 later, 3 cycles/request.
// Ready = !full on the registered count; WB_COALESCE_EN merges a same-row follower into one RMW.
module y_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 11,
    parameter int VAL_W  = 48,
    parameter int LANE_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    y_writeback_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = 4 * LANE_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [3:0]        r_oh   [DEPTH];
    logic [VAL_W-1:0]  r_val  [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state;
    logic [ROW_W-1:0]  r_row;
    logic [1:0]        r_npop;
    logic              r_err;
    logic [15:0]       r_wcount;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_head_ok;
    logic              w_pop_inv;
    logic              w_rd_en;
    logic              w_wr_en;
    logic [CNT_W-1:0]  w_pop_n;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [ADDR_W-1:0] w_head_addr;
    logic [3:0]        w_head_oh;
    logic [VAL_W-1:0]  w_head_val;
    logic [ROW_W-1:0]  w_merged;

    function automatic logic f_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = bus.wb_reqValid && !w_full && !bus.wb_flush;
    assign w_head_addr = r_addr[r_rd_ptr];
    assign w_head_oh   = r_oh[r_rd_ptr];
    assign w_head_val  = r_val[r_rd_ptr];
    assign w_head_ok   = f_onehot(w_head_oh);

    // Flush wins over an idle-state decision: nothing is started or dropped as an error.
    assign w_pop_inv = (r_state == S_IDLE) && !w_empty && !w_head_ok && !bus.wb_flush;
    assign w_rd_en   = !reset && (r_state == S_IDLE) && !w_empty && w_head_ok && !bus.wb_flush;
    assign w_wr_en   = !reset && (r_state == S_WRITE);

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] w_nxt_ptr;
    logic             w_coalesce;

    assign w_nxt_ptr  = r_rd_ptr + PTR_W'(1);
    assign w_coalesce = (r_count >= CNT_W'(2)) && !bus.wb_flush &&
                        (r_addr[w_nxt_ptr] == w_head_addr) && f_onehot(r_oh[w_nxt_ptr]);
`endif

    always_comb begin
        w_pop_n = '0;
        if (r_state == S_WRITE) begin
            w_pop_n = CNT_W'(r_npop);
        end else if (w_pop_inv) begin
            w_pop_n = CNT_W'(1);
        end
    end

    assign w_rd_ptr_nxt = r_rd_ptr + w_pop_n[PTR_W-1:0];

    // Only the value field of the selected lane changes; the tag bits pass through.
    always_comb begin
        w_merged = bus.sram_readData;
        for (int k = 0; k < 4; k++) begin
            if (w_head_oh[k]) begin
                w_merged[k*LANE_W +: VAL_W] = w_head_val;
            end
        end
`ifdef WB_COALESCE_EN
        if (w_coalesce) begin
            for (int k = 0; k < 4; k++) begin
                if (r_oh[w_nxt_ptr][k]) begin
                    w_merged[k*LANE_W +: VAL_W] = r_val[w_nxt_ptr];
                end
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= bus.wb_reqAddr;
            r_oh[r_wr_ptr]   <= bus.wb_reqOneHot;
            r_val[r_wr_ptr]  <= bus.wb_reqVal;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.wb_flush) begin
            // Keep only the in-flight head; in S_WRITE it is retired this same edge.
            case (r_state)
                S_WAIT: begin
                    r_wr_ptr <= r_rd_ptr + PTR_W'(1);
                    r_count  <= CNT_W'(1);
                end
                S_WRITE: begin
                    r_rd_ptr <= w_rd_ptr_nxt;
                    r_wr_ptr <= w_rd_ptr_nxt;
                    r_count  <= '0;
                end
                default: begin
                    r_wr_ptr <= r_rd_ptr;
                    r_count  <= '0;
                end
            endcase
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= r_count + CNT_W'(w_push) - w_pop_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_npop   <= 2'd1;
            r_err    <= 1'b0;
            r_wcount <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.wb_flush && !w_empty) begin
                        if (w_head_ok) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    r_row <= w_merged;
`ifdef WB_COALESCE_EN
                    r_npop <= w_coalesce ? 2'd2 : 2'd1;
`else
                    r_npop <= 2'd1;
`endif
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_wcount <= r_wcount + 16'(r_npop);
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wb_reqReady    = !w_full;
    assign bus.sram_readEn    = w_rd_en;
    assign bus.sram_readAddr  = w_rd_en ? w_head_addr : '0;
    assign bus.sram_writeEn   = w_wr_en;
    assign bus.sram_writeAddr = w_wr_en ? w_head_addr : '0;
    assign bus.sram_writeData = w_wr_en ? r_row : '0;
    assign bus.wb_idle        = w_empty && (r_state == S_IDLE);
    assign bus.wb_errOneHot   = r_err;
    assign bus.wb_writeCount  = r_wcount;
endmodule

// File: tb/tb_y_writeback_buffer.sv
// Bench for y_writeback_buffer: directed scenarios plus random traffic against a queue-based reference model.
// Includes a behavioural SRAM with one-cycle read latency.
module tb_y_writeback_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 11;
    localparam int VAL_W  = 48;
    localparam int ROWS   = 2048;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        oh;
        logic [VAL_W-1:0]  val;
    } req_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    y_writeback_buffer_if #(.ADDR_W(ADDR_W), .VAL_W(VAL_W), .ROW_W(256)) wb ();

    y_writeback_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .VAL_W(VAL_W), .LANE_W(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(wb)
    );

    logic [255:0] sram [ROWS] = '{default: '1};
    always @(posedge clock) begin
        if (wb.sram_readEn) wb.sram_readData <= sram[wb.sram_readAddr];
        if (wb.sram_writeEn) sram[wb.sram_writeAddr] <= wb.sram_writeData;
    end

    // Reference model: queue of accepted requests, RMW phase, committed memory image.
    req_t         mq[$];
    int           ph = 0;
    int           npop = 1;
    logic         m_err = 1'b0;
    logic [15:0]  m_cnt = '0;
    logic [255:0] mmem [ROWS] = '{default: '1};

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_wr = 0;
    int rd_cyc = 0;
    int wr_cyc = 0;
    int push_edge = 0;
    int wr_cycles[$];
    bit saw_full = 0;
    logic [255:0]      last_wdata = '0;
    logic [ADDR_W-1:0] last_waddr = '0;

    int pe, n0, r0;
    logic [15:0]  c0;
    logic [255:0] erow, row;
    bit           rv, rf;
    logic [3:0]   roh;

    function automatic bit oh_ok(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] r, input req_t q);
        logic [255:0] t;
        t = r;
        for (int k = 0; k < 4; k++) if (q.oh[k]) t[k*64 +: 48] = q.val;
        return t;
    endfunction

    function automatic logic [VAL_W-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[VAL_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit f, push;
        req_t nr;
        logic [255:0] r;
        f  = wb.wb_flush;
        nr = '{addr: wb.wb_reqAddr, oh: wb.wb_reqOneHot, val: wb.wb_reqVal};
        push = wb.wb_reqValid && (mq.size() < DEPTH) && !f;
        if (reset) begin
            mq.delete();
            ph = 0; npop = 1; m_err = 1'b0; m_cnt = '0;
            return;
        end
        case (ph)
            0: begin
                if (f) mq.delete();
                else if (mq.size() > 0) begin
                    if (oh_ok(mq[0].oh)) ph = 1;
                    else begin void'(mq.pop_front()); m_err = 1'b1; end
                end
            end
            1: begin
                if (f) while (mq.size() > 1) void'(mq.pop_back());
                npop = 1;
`ifdef WB_COALESCE_EN
                if (mq.size() >= 2 && mq[1].addr == mq[0].addr && oh_ok(mq[1].oh)) npop = 2;
`endif
                ph = 2;
            end
            default: begin
                r = merge(mmem[mq[0].addr], mq[0]);
                if (npop == 2) r = merge(r, mq[1]);
                mmem[mq[0].addr] = r;
                for (int i = 0; i < npop; i++) void'(mq.pop_front());
                m_cnt = m_cnt + 16'(npop);
                if (f) mq.delete();
                ph = 0;
            end
        endcase
        if (push) mq.push_back(nr);
    endtask

    task automatic check_cycle();
        bit e_rd, e_wr;
        logic [255:0] e_row;
        chk("ready", wb.wb_reqReady, mq.size() < DEPTH);
        chk("idle", wb.wb_idle, (mq.size() == 0) && (ph == 0));
        chk("err", wb.wb_errOneHot, m_err);
        chk("wcount", wb.wb_writeCount, m_cnt);
        e_rd = !reset && (ph == 0) && (mq.size() > 0) && oh_ok(mq[0].oh) && !wb.wb_flush;
        chk("rd_en", wb.sram_readEn, e_rd);
        if (e_rd) chk("rd_addr", wb.sram_readAddr, mq[0].addr);
        e_wr = !reset && (ph == 2);
        chk("wr_en", wb.sram_writeEn, e_wr);
        if (e_wr) begin
            e_row = merge(mmem[mq[0].addr], mq[0]);
            if (npop == 2) e_row = merge(e_row, mq[1]);
            chk("wr_addr", wb.sram_writeAddr, mq[0].addr);
            chk("wr_data", wb.sram_writeData, e_row);
        end
        if (wb.sram_readEn) begin n_rd++; rd_cyc = cyc + 1; end
        if (wb.sram_writeEn) begin
            n_wr++; wr_cyc = cyc + 1; wr_cycles.push_back(cyc + 1);
            last_wdata = wb.sram_writeData; last_waddr = wb.sram_writeAddr;
        end
        if (!wb.wb_reqReady) saw_full = 1;
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
        model_step();
    end

    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            check_cycle();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input logic [ADDR_W-1:0] a, input logic [3:0] oh,
                         input logic [VAL_W-1:0] val, input bit f);
        wb.wb_reqValid  = v;
        wb.wb_reqAddr   = a;
        wb.wb_reqOneHot = oh;
        wb.wb_reqVal    = val;
        wb.wb_flush     = f;
    endtask

    task automatic bus_idle();
        drive(1'b0, '0, 4'd0, '0, 1'b0);
    endtask

    task automatic push_req(input logic [ADDR_W-1:0] a, input logic [3:0] oh, input logic [VAL_W-1:0] val);
        bit ok;
        int guard;
        guard = 0;
        drive(1'b1, a, oh, val, 1'b0);
        do begin
            @(negedge clock);
            ok = wb.wb_reqReady;
            step();
            guard++;
        end while (!ok && guard < 50);
        if (!ok) chk("push_timeout", 1'b0, 1'b1);
        push_edge = cyc;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clock);
            done = wb.wb_idle;
            step();
        end
        if (!done) chk("idle_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        bus_idle();
        wb.sram_readData = '0;
        reset = 1'b1;
        repeat (3) step();
        chk("rst_rd_addr", wb.sram_readAddr, 11'd0);
        chk("rst_wr_addr", wb.sram_writeAddr, 11'd0);
        chk("rst_wr_data", wb.sram_writeData, 256'd0);
        reset = 1'b0;
        step();

        // Single request into an all-ones row.
        push_req(11'd5, 4'b0100, 48'hAAAAAA555555);
        pe = push_edge;
        bus_idle();
        wait_idle(20);
        chk("single_rd_cyc", rd_cyc, pe + 1);
        chk("single_wr_cyc", wr_cyc, pe + 3);
        chk("single_wr_addr", last_waddr, 11'd5);
        erow = '1;
        erow[175:128] = 48'hAAAAAA555555;
        chk("single_wr_data", last_wdata, erow);
        chk("single_wcount", wb.wb_writeCount, 16'd1);

        // Back-to-back pushes until the FIFO fills.
        n0 = n_wr; wr_cycles.delete(); saw_full = 0;
        for (int i = 0; i < 6; i++) push_req(11'(16 + i), 4'(1 << (i % 4)), rnd48());
        bus_idle();
        wait_idle(100);
        chk("fill_writes", n_wr - n0, 6);
        chk("fill_full_seen", saw_full, 1'b1);
        for (int i = 1; i < wr_cycles.size(); i++) chk("fill_spacing", wr_cycles[i] - wr_cycles[i-1], 3);
        chk("fill_idle", wb.wb_idle, 1'b1);

        // Invalid one-hot is dropped with a sticky error.
        n0 = n_wr; r0 = n_rd;
        push_req(11'd7, 4'b0011, rnd48());
        bus_idle();
        wait_idle(20);
        chk("inv_no_rd", n_rd - r0, 0);
        chk("inv_no_wr", n_wr - n0, 0);
        chk("inv_err", wb.wb_errOneHot, 1'b1);
        push_req(11'd7, 4'b0001, rnd48());
        bus_idle();
        wait_idle(20);
        chk("inv_then_wr", n_wr - n0, 1);
        chk("inv_err_sticky", wb.wb_errOneHot, 1'b1);

        // Flush in the S_WAIT cycle, with a simultaneous (discarded) push.
        n0 = n_wr; r0 = n_rd; c0 = m_cnt;
        push_req(11'd3, 4'b0001, rnd48());
        push_req(11'd4, 4'b0010, rnd48());
        drive(1'b1, 11'd6, 4'b0100, rnd48(), 1'b1);
        step();
        bus_idle();
        wait_idle(20);
        chk("flush_reads", n_rd - r0, 1);
        chk("flush_writes", n_wr - n0, 1);
        chk("flush_wcount", wb.wb_writeCount, c0 + 16'd1);
        chk("flush_idle", wb.wb_idle, 1'b1);

        // Reset while the RMW waits for read data.
        n0 = n_wr; erow = mmem[12];
        push_req(11'd12, 4'b1000, rnd48());
        bus_idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_ready", wb.wb_reqReady, 1'b1);
        chk("rst2_idle", wb.wb_idle, 1'b1);
        chk("rst2_err", wb.wb_errOneHot, 1'b0);
        chk("rst2_wcount", wb.wb_writeCount, 16'd0);
        chk("rst2_rd_en", wb.sram_readEn, 1'b0);
        chk("rst2_wr_en", wb.sram_writeEn, 1'b0);
        chk("rst2_wr_data", wb.sram_writeData, 256'd0);
        repeat (4) step();
        chk("rst2_no_wr", n_wr - n0, 0);
        row = sram[12];
        chk("rst2_row_kept", row, erow);

        // Two lanes of the same row back to back.
        n0 = n_wr; c0 = m_cnt;
        push_req(11'd9, 4'b0001, 48'd1);
        push_req(11'd9, 4'b1000, 48'd2);
        bus_idle();
        wait_idle(30);
`ifdef WB_COALESCE_EN
        chk("coal_writes", n_wr - n0, 1);
`else
        chk("coal_writes", n_wr - n0, 2);
`endif
        row = sram[9];
        chk("coal_lane0", row[47:0], 48'd1);
        chk("coal_lane3", row[239:192], 48'd2);
        chk("coal_tag0", row[63:48], 16'hFFFF);
        chk("coal_wcount", wb.wb_writeCount, c0 + 16'd2);

        // Random traffic on a few rows with occasional flush, bad one-hot and reset.
        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(0, 99) < 60);
            rf = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 9) == 0) roh = 4'($urandom_range(0, 15));
            else roh = 4'(1 << $urandom_range(0, 3));
            drive(rv, 11'($urandom_range(0, 7)), roh, rnd48(), rf);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        bus_idle();
        wait_idle(50);
        for (int a = 0; a < 8; a++) begin
            row = sram[a];
            chk("final_row", row, mmem[a]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
